daccess_axi_bridge: RTL and testbench
=====================================

Name: daccess_axi_bridge

Overview:
- Responder for the CPU core's data-access (daccess) request interface; converts each daccess read or write into one single-beat AXI3 transaction on the top-level AXI master ports.
- Sits between the core and the AXI interconnect inside the CPU top; replaces the constant ties on daccess_valid and daccess_wresp.
- One transaction outstanding at a time; no bursts, no reordering.

Parameters:
- AXI_ID, 4'd1, constant driven on arid, awid and wid.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- daccess_ren  in  4  read byte mask; nonzero means read request.
- daccess_wen  in  4  write byte strobes; nonzero means write request.
- daccess_addr  in  32  byte address.
- daccess_wdata  in  32  write data.
- daccess_valid  out  1  one-cycle pulse: read data valid.
- daccess_rdata  out  32  read data; held until the next read completes.
- daccess_wresp  out  1  one-cycle pulse: write complete.
- daccess_err  out  1  one-cycle pulse, coincident with valid/wresp, when rresp/bresp != 2'b00.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI read address channel.
- arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready  out  1.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1; awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready  in  1.
- bid/bresp/bvalid  in  4/2/1; bready  out  1.

Behaviour:
- Constants: arlen = awlen = 0; arsize = awsize = 3'b010; arburst = awburst = 2'b01; lock = cache = prot = 0; wlast = 1.
- Reset (async, aresetn = 0): state IDLE. All valid/ready outputs, daccess_valid, daccess_wresp and daccess_err are 0. daccess_rdata, araddr, awaddr, wdata and wstrb are 0.
- FSM states: IDLE, AR, R, W, B, DONE.
- IDLE:
  - If wen != 0, latch addr into awaddr, wdata into wdata, wen into wstrb, then go to W. Write wins if ren and wen are both nonzero.
  - Else if ren != 0, latch addr into araddr and go to AR.
  - araddr and awaddr are word-aligned: addr[1:0] is forced to 0.
- AR: arvalid = 1. On arvalid & arready, go to R.
- R:
  - rready = 1.
  - On rvalid & rready, capture rdata and set err = (rresp != 0). rlast and rid are ignored.
  - Go to DONE with the read flag set.
- W:
  - awvalid and wvalid are asserted together on entry.
  - Each channel deasserts independently on its own handshake and is never re-raised.
  - Move to B in the cycle after both handshakes have completed, in either order or simultaneously.
- B: bready = 1. On bvalid, set err = (bresp != 0) and go to DONE.
- DONE:
  - Exactly one cycle. Pulse daccess_valid (read) or daccess_wresp (write), with daccess_err if err was set. Return to IDLE.
  - daccess_rdata holds the captured value from the DONE cycle onward.
- Core contract: request inputs are held stable until the completion pulse. A request still present in the cycle after DONE is sampled as a new request.
- Read latency with zero-wait slave: request present at IDLE cycle T; arvalid at T+1; R at T+2 with rvalid; daccess_valid at T+3.
- Write latency: wresp 3 cycles after IDLE sampling when the slave handshakes immediately.
- Handshake rules:
  - No valid signal drops before its handshake.
  - Address and data remain stable while their valid is high.
  - Inputs changing mid-transaction are ignored.
- Reset asserted mid-transaction: the bridge returns to IDLE immediately with all valids low. It does not wait for outstanding responses.

Test Plan:
- Read, zero-wait slave: ren = 4'hF, addr = 32'h1C000104, slave returns 32'hDEADBEEF with rresp 0 -> araddr 32'h1C000104 and arsize 2; daccess_valid pulses exactly once, 3 cycles after the request; daccess_rdata = 32'hDEADBEEF; err = 0.
- Write with awready delayed 3 cycles and wready immediate: wen = 4'b0011, wdata = 32'h12345678 -> wvalid drops after 1 cycle; awvalid is held 4 cycles with awaddr stable; bready asserted; one daccess_wresp pulse after bvalid; wstrb = 4'b0011.
- Simultaneous ren = 4'hF and wen = 4'hF -> AW/W issued first and no arvalid; a read follows only if ren is still held after the wresp pulse.
- Error responses: rresp = 2'b10 -> daccess_valid and daccess_err pulse in the same cycle. bresp = 2'b11 -> daccess_wresp and daccess_err pulse together.
- aresetn dropped while in R -> all outputs are 0 in the same cycle. After release with no request, arvalid stays 0 and no completion pulse occurs.
- Back-to-back reads to 32'h0 then 32'h4 with arready low for 2 cycles -> two separate AR handshakes, exactly one valid pulse each, and rdata updated in order.

Source files
------------

// File: rtl/daccess_axi_bridge_if.sv
// daccess_axi_bridge_if: AXI3 read/write channel bundle between the daccess bridge and the interconnect
interface daccess_axi_bridge_if;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [1:0] arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  logic [3:0] awid;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [1:0] awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [3:0] wid;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input arready,
    input rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input wready,
    input bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input rready,
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input bready
  );
endinterface

// File: rtl/daccess_axi_bridge.sv
// daccess_axi_bridge: turns each core daccess read/write into one single-beat AXI3 transaction
module daccess_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  daccess_ren,
  input  logic [3:0]  daccess_wen,
  input  logic [31:0] daccess_addr,
  input  logic [31:0] daccess_wdata,
  output logic        daccess_valid,
  output logic [31:0] daccess_rdata,
  output logic        daccess_wresp,
  output logic        daccess_err,
  daccess_axi_bridge_if.master axi
);
  typedef enum logic [2:0] {IDLE, AR, R, W, B, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, err_q, err_d, rd_q, rd_d;
  logic aw_done, w_done, unused;
  assign unused = ^{axi.rid, axi.rlast, axi.bid};
  // A channel counts as done once its valid has dropped or it handshakes this cycle
  assign aw_done = !awvalid_q || axi.awready;
  assign w_done = !wvalid_q || axi.wready;
  always_comb begin
    state_d = state_q;
    araddr_d = araddr_q;
    awaddr_d = awaddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    awvalid_d = awvalid_q && !axi.awready;
    wvalid_d = wvalid_q && !axi.wready;
    err_d = err_q;
    rd_d = rd_q;
    case (state_q)
      IDLE: if (|daccess_wen) begin
        state_d = W;
        awaddr_d = {daccess_addr[31:2], 2'b00};
        wdata_d = daccess_wdata;
        wstrb_d = daccess_wen;
        awvalid_d = 1'b1;
        wvalid_d = 1'b1;
        rd_d = 1'b0;
      end else if (|daccess_ren) begin
        state_d = AR;
        araddr_d = {daccess_addr[31:2], 2'b00};
        rd_d = 1'b1;
      end
      AR: state_d = axi.arready ? R : AR;
      R: if (axi.rvalid) begin
        state_d = DONE;
        rdata_d = axi.rdata;
        err_d = |axi.rresp;
      end
      W: state_d = (aw_done && w_done) ? B : W;
      B: if (axi.bvalid) begin
        state_d = DONE;
        err_d = |axi.bresp;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      araddr_q <= '0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      araddr_q <= araddr_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      err_q <= err_d;
      rd_q <= rd_d;
    end
  end
  assign daccess_valid = (state_q == DONE) && rd_q;
  assign daccess_wresp = (state_q == DONE) && !rd_q;
  assign daccess_err = (state_q == DONE) && err_q;
  assign daccess_rdata = rdata_q;
  assign axi.arid = AXI_ID;
  assign axi.araddr = araddr_q;
  assign axi.arlen = 8'd0;
  assign axi.arsize = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arlock = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot = 3'd0;
  assign axi.arvalid = state_q == AR;
  assign axi.rready = state_q == R;
  assign axi.awid = AXI_ID;
  assign axi.awaddr = awaddr_q;
  assign axi.awlen = 8'd0;
  assign axi.awsize = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awlock = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot = 3'd0;
  assign axi.awvalid = awvalid_q;
  assign axi.wid = AXI_ID;
  assign axi.wdata = wdata_q;
  assign axi.wstrb = wstrb_q;
  assign axi.wlast = 1'b1;
  assign axi.wvalid = wvalid_q;
  assign axi.bready = state_q == B;
endmodule

// File: tb/tb_daccess_axi_bridge.sv
// tb_daccess_axi_bridge: randomized bench with a word-memory reference model and a scripted AXI slave
module tb_daccess_axi_bridge;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [3:0] daccess_ren = '0;
  logic [3:0] daccess_wen = '0;
  logic [31:0] daccess_addr = '0;
  logic [31:0] daccess_wdata = '0;
  logic daccess_valid, daccess_wresp, daccess_err;
  logic [31:0] daccess_rdata;
  int vectors = 0;
  int errors = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] slv_mem [int];
  daccess_axi_bridge_if axi ();
  daccess_axi_bridge dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .daccess_ren(daccess_ren),
    .daccess_wen(daccess_wen),
    .daccess_addr(daccess_addr),
    .daccess_wdata(daccess_wdata),
    .daccess_valid(daccess_valid),
    .daccess_rdata(daccess_rdata),
    .daccess_wresp(daccess_wresp),
    .daccess_err(daccess_err),
    .axi(axi)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  function automatic int key(input logic [31:0] a);
    return int'(a[31:2]);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] m;
    m = old;
    for (int j = 0; j < 4; j++) if (strb[j]) m[8*j +: 8] = nw[8*j +: 8];
    return m;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(key(a)) ? ref_mem[key(a)] : 32'h0;
  endfunction
  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(key(a)) ? slv_mem[key(a)] : 32'h0;
  endfunction
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[key(a)] = d;
    slv_mem[key(a)] = d;
  endtask
  task automatic chk_quiet(input string tag);
    chk(tag, {31'd0, |{axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                      daccess_valid, daccess_wresp, daccess_err}}, 32'd0);
  endtask
  task automatic do_rd(input logic [31:0] addr, input logic [3:0] ren, input int ar_dly,
                       input int r_dly, input logic [1:0] resp);
    logic [31:0] sa;
    daccess_ren = ren;
    daccess_addr = addr;
    step();
    chk("arvalid_up", axi.arvalid, 1);
    chk("araddr", axi.araddr, {addr[31:2], 2'b00});
    chk("ar_consts", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
        {4'd1, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
    chk("rd_no_aw", {axi.awvalid, axi.wvalid}, 0);
    for (int i = 0; i < ar_dly; i++) begin
      daccess_addr = $urandom;
      step();
      chk("arvalid_hold", axi.arvalid, 1);
      chk("araddr_stable", axi.araddr, {addr[31:2], 2'b00});
    end
    sa = axi.araddr;
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    chk("arvalid_down", axi.arvalid, 0);
    chk("rready", axi.rready, 1);
    for (int i = 0; i < r_dly; i++) begin
      step();
      chk("rready_hold", axi.rready, 1);
      chk("rd_early", daccess_valid, 0);
    end
    axi.rvalid = 1'b1;
    axi.rdata = slv_rd(sa);
    axi.rresp = resp;
    axi.rlast = 1'b1;
    axi.rid = 4'd1;
    step();
    axi.rvalid = 1'b0;
    axi.rdata = $urandom;
    axi.rresp = 2'b00;
    chk("rd_valid", daccess_valid, 1);
    chk("rd_err", daccess_err, resp != 2'b00);
    chk("rd_no_wresp", daccess_wresp, 0);
    chk("rdata", daccess_rdata, ref_rd(addr));
    daccess_ren = '0;
    step();
    chk_quiet("rd_once");
    chk("rdata_hold", daccess_rdata, ref_rd(addr));
  endtask
  task automatic do_wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd,
                       input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp);
    logic [31:0] sa, sd;
    logic [3:0] ss;
    int n;
    daccess_wen = wen;
    daccess_addr = addr;
    daccess_wdata = wd;
    step();
    chk("aw_w_up", {axi.awvalid, axi.wvalid}, 2'b11);
    chk("wstrb", axi.wstrb, wen);
    chk("wdata", axi.wdata, wd);
    chk("aw_consts", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot,
                      axi.wid, axi.wlast}, {4'd1, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 1'b1});
    n = aw_dly > w_dly ? aw_dly : w_dly;
    sa = '0;
    sd = '0;
    ss = '0;
    for (int k = 0; k <= n; k++) begin
      chk("awvalid", axi.awvalid, k <= aw_dly);
      chk("wvalid", axi.wvalid, k <= w_dly);
      chk("wr_no_ar", {axi.arvalid, axi.bready}, 0);
      if (k <= aw_dly) chk("awaddr_stable", axi.awaddr, {addr[31:2], 2'b00});
      if (k == aw_dly) sa = axi.awaddr;
      if (k == w_dly) begin
        sd = axi.wdata;
        ss = axi.wstrb;
      end
      axi.awready = k == aw_dly;
      axi.wready = k == w_dly;
      step();
    end
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    chk("bready", axi.bready, 1);
    chk("aw_w_down", {axi.awvalid, axi.wvalid}, 0);
    for (int i = 0; i < b_dly; i++) begin
      step();
      chk("bready_hold", axi.bready, 1);
      chk("wr_early", daccess_wresp, 0);
    end
    slv_mem[key(sa)] = merge(slv_rd(sa), sd, ss);
    axi.bvalid = 1'b1;
    axi.bresp = resp;
    axi.bid = 4'd1;
    step();
    axi.bvalid = 1'b0;
    axi.bresp = 2'b00;
    ref_mem[key(addr)] = merge(ref_rd(addr), wd, wen);
    chk("wresp", daccess_wresp, 1);
    chk("wr_err", daccess_err, resp != 2'b00);
    chk("wr_no_valid", daccess_valid, 0);
    daccess_wen = '0;
    step();
    chk_quiet("wr_once");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a;
    logic [1:0] rs;
    {axi.arready, axi.rvalid, axi.rlast, axi.awready, axi.wready, axi.bvalid} = '0;
    axi.rid = '0;
    axi.rdata = '0;
    axi.rresp = '0;
    axi.bid = '0;
    axi.bresp = '0;
    #3;
    chk_quiet("reset_ctrl");
    chk("reset_data", daccess_rdata | axi.araddr | axi.awaddr | axi.wdata | {28'd0, axi.wstrb}, 0);
    step();
    aresetn = 1'b1;
    step();
    chk_quiet("idle_after_reset");
    preload(32'h1C000104, 32'hDEADBEEF);
    do_rd(32'h1C000104, 4'hF, 0, 0, 2'b00);
    do_wr(32'h1C000200, 4'b0011, 32'h12345678, 3, 0, 1, 2'b00);
    do_rd(32'h1C000203, 4'hF, 1, 1, 2'b00);
    daccess_ren = 4'hF;
    do_wr(32'h1C000300, 4'hF, 32'hCAFEF00D, 0, 2, 0, 2'b00);
    do_rd(32'h1C000300, 4'hF, 0, 0, 2'b00);
    do_rd(32'h1C000104, 4'hF, 0, 2, 2'b10);
    do_wr(32'h1C000104, 4'b1100, 32'hA5A5A5A5, 1, 1, 0, 2'b11);
    preload(32'h0, 32'h11111111);
    preload(32'h4, 32'h22222222);
    do_rd(32'h0, 4'hF, 2, 0, 2'b00);
    do_rd(32'h4, 4'hF, 2, 0, 2'b00);
    daccess_ren = 4'hF;
    daccess_addr = 32'h1C000104;
    step();
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
    chk("pre_reset_rready", axi.rready, 1);
    aresetn = 1'b0;
    #1;
    chk_quiet("midreset_ctrl");
    chk("midreset_data", daccess_rdata | axi.araddr | axi.awaddr | axi.wdata | {28'd0, axi.wstrb}, 0);
    daccess_ren = '0;
    step();
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_quiet("post_reset_quiet");
    end
    for (int t = 0; t < 60; t++) begin
      a = 32'h20000000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1)
        do_wr(a, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), rs);
      else
        do_rd(a, 4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3), rs);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
